// File: rtl/data_cache_pkg.sv
// Shared constants, FSM state codes and address helpers for the data cache.
package data_cache_pkg;

    localparam int LINE_BITS = 512;
    localparam int WORD_W    = 32;
    localparam int OFFSET_W  = 6;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ACK  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_FILL    = 3'd3;
    localparam logic [2:0] S_WR_ACK  = 3'd4;
    localparam logic [2:0] S_WR_WAIT = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    // Byte address rounded down to its 64-byte line.
    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~32'h0000_003F;
    endfunction

    // Byte address rounded down to its 32-bit word.
    function automatic logic [31:0] word_base(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

    // Word w of a cache line (word w = bits [32w+31:32w]).
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                   input logic [3:0] w);
        return line[w*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: whole-line fill, single-word update, combinational read.
module data_cache_array
    import data_cache_pkg::*;
#(
    parameter int LINES   = 16,
    parameter int INDEX_W = $clog2(LINES),
    parameter int TAG_W   = 22
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [INDEX_W-1:0]   rd_index,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 fill_en,
    input  logic [INDEX_W-1:0]   fill_index,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic [LINE_BITS-1:0] fill_line,
    input  logic                 wr_en,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [3:0]           wr_word,
    input  logic [WORD_W-1:0]    wr_data
);

    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [TAG_W-1:0]     tag_d  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];
    logic [LINE_BITS-1:0] data_d [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

    // Next-state of storage: a fill replaces a line, a store hit patches one word.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[fill_index] = 1'b1;
            tag_d[fill_index]   = fill_tag;
            data_d[fill_index]  = fill_line;
        end
        if (wr_en) begin
            data_d[wr_index][wr_word*WORD_W +: WORD_W] = wr_data;
        end
    end

    // Only valid bits need reset; tags and data are qualified by them.
    always_ff @(posedge clock) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Tag and data storage.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module data_cache_controller
    import data_cache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [WORD_W-1:0]    cpu_wdata,
    output logic                 cpu_ready,
    output logic [WORD_W-1:0]    cpu_rdata,
    output logic [ADDR_W-1:0]    mem_read_address,
    output logic                 mem_read_request,
    input  logic                 mem_read_enable,
    input  logic [LINE_BITS-1:0] mem_read_data,
    output logic [ADDR_W-1:0]    mem_write_address,
    output logic                 mem_write_request,
    output logic [WORD_W-1:0]    mem_write_data,
    input  logic                 mem_write_done,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-3:0] waddr_q, waddr_d;   // registered request as a word address
    logic [WORD_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [ADDR_W-1:0] mem_read_address_q, mem_read_address_d;
    logic              mem_read_request_q, mem_read_request_d;
    logic [ADDR_W-1:0] mem_write_address_q, mem_write_address_d;
    logic              mem_write_request_q, mem_write_request_d;
    logic [WORD_W-1:0] mem_write_data_q, mem_write_data_d;
    logic [31:0]       hit_count_q, hit_count_d;
    logic [31:0]       miss_count_q, miss_count_d;

    logic [INDEX_W-1:0]   cpu_index, fill_index;
    logic [TAG_W-1:0]     cpu_tag, fill_tag;
    logic [3:0]           fill_word;
    logic                 rd_valid, lookup_hit, fill_en, wr_en;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;

    assign cpu_index  = cpu_addr[OFFSET_W +: INDEX_W];
    assign cpu_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
    assign fill_index = waddr_q[OFFSET_W-2 +: INDEX_W];
    assign fill_tag   = waddr_q[ADDR_W-3 -: TAG_W];
    assign fill_word  = waddr_q[3:0];
    assign lookup_hit = rd_valid && (rd_tag == cpu_tag);

    data_cache_array #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .rd_index   (cpu_index),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .fill_en    (fill_en),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_line  (mem_read_data),
        .wr_en      (wr_en),
        .wr_index   (cpu_index),
        .wr_word    (cpu_addr[5:2]),
        .wr_data    (cpu_wdata)
    );

    // Controller FSM: lookup in IDLE, one memory transaction at a time, then RESP.
    always_comb begin
        state_d             = state_q;
        waddr_d             = waddr_q;
        cpu_rdata_d         = cpu_rdata_q;
        mem_read_address_d  = mem_read_address_q;
        mem_read_request_d  = 1'b0;
        mem_write_address_d = mem_write_address_q;
        mem_write_request_d = 1'b0;
        mem_write_data_d    = mem_write_data_q;
        hit_count_d         = hit_count_q;
        miss_count_d        = miss_count_q;
        fill_en             = 1'b0;
        wr_en               = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    waddr_d = cpu_addr[ADDR_W-1:2];
                    if (cpu_we) begin
                        // Write-through: every store goes to memory; a hit also patches the line.
                        mem_write_address_d = word_base(cpu_addr);
                        mem_write_data_d    = cpu_wdata;
                        mem_write_request_d = 1'b1;
                        wr_en               = lookup_hit;
                        state_d             = S_WR_ACK;
                    end else if (lookup_hit) begin
                        cpu_rdata_d = line_word(rd_line, cpu_addr[5:2]);
                        hit_count_d = hit_count_q + 32'd1;
                        state_d     = S_RESP;
                    end else begin
                        mem_read_address_d = line_base(cpu_addr);
                        mem_read_request_d = 1'b1;
                        miss_count_d       = miss_count_q + 32'd1;
                        state_d            = S_RD_ACK;
                    end
                end
            end
            S_RD_ACK:  if (!mem_read_enable) state_d = S_RD_WAIT;
            S_RD_WAIT: if (mem_read_enable)  state_d = S_FILL;
            S_FILL: begin
                fill_en     = 1'b1;
                cpu_rdata_d = line_word(mem_read_data, fill_word);
                state_d     = S_RESP;
            end
            S_WR_ACK:  if (!mem_write_done) state_d = S_WR_WAIT;
            S_WR_WAIT: if (mem_write_done)  state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State, request register, output registers and statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q             <= S_IDLE;
            waddr_q             <= '0;
            cpu_rdata_q         <= '0;
            mem_read_address_q  <= '0;
            mem_read_request_q  <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_request_q <= 1'b0;
            mem_write_data_q    <= '0;
            hit_count_q         <= '0;
            miss_count_q        <= '0;
        end else begin
            state_q             <= state_d;
            waddr_q             <= waddr_d;
            cpu_rdata_q         <= cpu_rdata_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_read_request_q  <= mem_read_request_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_request_q <= mem_write_request_d;
            mem_write_data_q    <= mem_write_data_d;
            hit_count_q         <= hit_count_d;
            miss_count_q        <= miss_count_d;
        end
    end

    assign cpu_ready         = (state_q == S_RESP);
    assign cpu_rdata         = cpu_rdata_q;
    assign mem_read_address  = mem_read_address_q;
    assign mem_read_request  = mem_read_request_q;
    assign mem_write_address = mem_write_address_q;
    assign mem_write_request = mem_write_request_q;
    assign mem_write_data    = mem_write_data_q;
    assign hit_count         = hit_count_q;
    assign miss_count        = miss_count_q;

endmodule

// File: tb/tb_data_cache_controller.sv
// Randomized bench for data_cache_controller against a line-presence + flat-memory model.
module tb_data_cache_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic [31:0]  mem_read_address;
    logic         mem_read_request;
    logic         mem_read_enable;
    logic [511:0] mem_read_data;
    logic [31:0]  mem_write_address;
    logic         mem_write_request;
    logic [31:0]  mem_write_data;
    logic         mem_write_done;
    logic [31:0]  hit_count, miss_count;

    always #5 clock = ~clock;

    data_cache_controller #(.LINES(16), .ADDR_W(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_ready         (cpu_ready),
        .cpu_rdata         (cpu_rdata),
        .mem_read_address  (mem_read_address),
        .mem_read_request  (mem_read_request),
        .mem_read_enable   (mem_read_enable),
        .mem_read_data     (mem_read_data),
        .mem_write_address (mem_write_address),
        .mem_write_request (mem_write_request),
        .mem_write_data    (mem_write_data),
        .mem_write_done    (mem_write_done),
        .hit_count         (hit_count),
        .miss_count        (miss_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Flat memory model; unwritten words have a fixed address-derived pattern.
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    function automatic logic [511:0] build_line(input logic [31:0] base);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = mem_rd(base + 32'(w * 4));
        return l;
    endfunction

    // Cache model: which line address each index holds, plus expected counters.
    bit          mv [16];
    logic [31:0] ml [16];
    logic [31:0] exp_hit, exp_miss;

    int          rd_lat = 0, wr_lat = 0;
    int          rd_reqs = 0, wr_reqs = 0, ready_cnt = 0;
    logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
    logic        prev_rr = 1'b0, prev_wr = 1'b0;

    // Read responder: enable low for rd_lat+1 cycles, then line data with enable high.
    always begin
        @(negedge clock);
        if (mem_read_request === 1'b1) begin
            rd_reqs++;
            last_rd_addr = mem_read_address;
            mem_read_enable = 1'b0;
            repeat (rd_lat + 1) @(negedge clock);
            mem_read_data = build_line(last_rd_addr);
            mem_read_enable = 1'b1;
        end
    end

    // Write responder: done low for wr_lat+1 cycles.
    always begin
        @(negedge clock);
        if (mem_write_request === 1'b1) begin
            wr_reqs++;
            last_wr_addr = mem_write_address;
            last_wr_data = mem_write_data;
            mem_write_done = 1'b0;
            repeat (wr_lat + 1) @(negedge clock);
            mem_write_done = 1'b1;
        end
    end

    // Request pulses must be one cycle; count ready pulses.
    always @(negedge clock) begin
        if (mem_read_request === 1'b1)  check("rd_pulse_width", 32'(prev_rr), 32'd0);
        if (mem_write_request === 1'b1) check("wr_pulse_width", 32'(prev_wr), 32'd0);
        prev_rr = mem_read_request;
        prev_wr = mem_write_request;
        if (cpu_ready === 1'b1) ready_cnt++;
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"},   32'(cpu_ready), 32'd0);
        check({pfx, "_rdata"},   cpu_rdata, 32'd0);
        check({pfx, "_rreq"},    32'(mem_read_request), 32'd0);
        check({pfx, "_wreq"},    32'(mem_write_request), 32'd0);
        check({pfx, "_raddr"},   mem_read_address, 32'd0);
        check({pfx, "_waddr"},   mem_write_address, 32'd0);
        check({pfx, "_wdata"},   mem_write_data, 32'd0);
        check({pfx, "_hits"},    hit_count, 32'd0);
        check({pfx, "_misses"},  miss_count, 32'd0);
    endtask

    // One CPU access; cyc counts negedges from request drive to ready sample.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int cyc);
        bit to;
        to = 1'b0;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        cyc = 0;
        rd = 'x;
        forever begin
            @(negedge clock);
            cyc++;
            if (cpu_ready === 1'b1) begin rd = cpu_rdata; break; end
            if (cyc > 2000) begin to = 1'b1; break; end
        end
        check("completes", 32'(to), 32'd0);
        @(posedge clock); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    // Access plus model prediction of data, hit/miss, latency and memory traffic.
    task automatic op(input bit we, input logic [31:0] a, input logic [31:0] d);
        int          idx, r0, w0, cyc;
        logic [31:0] line, rd;
        bit          hit;
        idx  = int'((a >> 6) % 16);
        line = a >> 6;
        hit  = mv[idx] && (ml[idx] == line);
        r0 = rd_reqs;
        w0 = wr_reqs;
        if (we) mem[a & ~32'h3] = d;
        access(we, a, d, rd, cyc);
        if (we) begin
            check("st_wr_reqs",  32'(wr_reqs - w0), 32'd1);
            check("st_rd_reqs",  32'(rd_reqs - r0), 32'd0);
            check("st_waddr",    last_wr_addr, a & ~32'h3);
            check("st_wdata",    last_wr_data, d);
            check("st_latency",  32'(cyc), 32'(wr_lat + 4));
        end else begin
            if (hit) exp_hit++;
            else begin
                exp_miss++;
                mv[idx] = 1'b1;
                ml[idx] = line;
            end
            check("ld_data",     rd, mem_rd(a & ~32'h3));
            check("ld_rd_reqs",  32'(rd_reqs - r0), hit ? 32'd0 : 32'd1);
            check("ld_wr_reqs",  32'(wr_reqs - w0), 32'd0);
            check("ld_latency",  32'(cyc), hit ? 32'd2 : 32'(rd_lat + 5));
            if (!hit) check("ld_raddr", last_rd_addr, a & ~32'h3F);
        end
        check("hit_count",  hit_count, exp_hit);
        check("miss_count", miss_count, exp_miss);
    endtask

    initial begin
        int r0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_read_enable = 1'b1; mem_write_done = 1'b1; mem_read_data = '0;
        mem[32'h40] = 32'hDEAD_BEEF;
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst");
        @(posedge clock); #1 reset = 1'b0;

        // Directed sequence.
        rd_lat = 199; wr_lat = 2;
        op(1'b0, 32'h0000_0040, 32'h0);
        check("cold_word0", cpu_rdata, 32'hDEAD_BEEF);
        rd_lat = 3;
        op(1'b0, 32'h0000_0044, 32'h0);
        op(1'b1, 32'h0000_0048, 32'h1234_5678);
        op(1'b0, 32'h0000_0048, 32'h0);
        op(1'b1, 32'h0000_0400, 32'hCAFE_F00D);
        op(1'b0, 32'h0000_0400, 32'h0);
        op(1'b0, 32'h0000_0440, 32'h0);
        op(1'b0, 32'h0000_0040, 32'h0);

        // Reset while the controller waits in RD_WAIT on an uncached line.
        rd_lat = 12;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_01C0;
        repeat (6) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1; cpu_req = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("midrst");
        r0 = ready_cnt;
        @(posedge clock); #1 reset = 1'b0;
        model_reset();
        repeat (25) @(negedge clock);
        check("late_ready", 32'(ready_cnt - r0), 32'd0);
        check("late_hits",  hit_count, 32'd0);
        rd_lat = 1;
        op(1'b0, 32'h0000_0040, 32'h0);

        // Randomized mix of loads and stores over a small, conflicting address range.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            bit          we;
            a = ($urandom & 32'h0000_0FFF) | (($urandom_range(0, 3) == 0) ? 32'hABC0_0000 : 32'h0);
            we = ($urandom_range(0, 2) == 0);
            rd_lat = $urandom_range(0, 4);
            wr_lat = $urandom_range(0, 4);
            op(we, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
